// File: rtl/aes_pkg.sv
// Shared AES definitions used by the AddRoundKey datapath and the key bank.
// Holds the block width, the round counts for the three key sizes, the
// round-index and state-word types, and the key-slot wrap helper.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;

    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    typedef logic [3:0]             round_idx_t;
    typedef logic [AES_BLOCK_W-1:0] state_word_t;

    // Maps any 4-bit round index onto a valid key slot 0..nr. An out-of-range
    // round is folded back into the bank, so the stream keeps flowing instead
    // of stalling.
    function automatic round_idx_t wrap_slot(input round_idx_t r, input int nr);
        int v;
        v = int'(r) % (nr + 1);
        return round_idx_t'(v);
    endfunction

endpackage

// File: rtl/ae_key_bank.sv
// Round-key register file: NR+1 slots of 128 bits with asynchronous reset,
// one write port and a combinational read that returns the DATA_W-bit slice
// of a slot for a given beat (beat 0 = most-significant bytes). The
// inverse-cipher path reuses this bank as is.
module ae_key_bank
    import aes_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int NR     = 10,
    localparam int BEATS  = AES_BLOCK_W / DATA_W,
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [3:0]        wr_slot,
    input  logic [127:0]      wr_data,
    input  logic [3:0]        rd_slot,
    input  logic [BEAT_W-1:0] rd_beat,
    output logic [DATA_W-1:0] rd_data
);

    state_word_t key_mem [0:NR];
    state_word_t sel_key;

    // Key storage: cleared on reset, writes to slots beyond NR are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= NR; s++) begin
                key_mem[s] <= '0;
            end
        end else if (we && (int'(wr_slot) <= NR)) begin
            key_mem[wr_slot] <= wr_data;
        end
    end

    // Read path: pick the slot, then the beat's slice, MSB slice first.
    always_comb begin
        sel_key = '0;
        if (int'(rd_slot) <= NR) begin
            sel_key = key_mem[rd_slot];
        end
        rd_data = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (rd_beat == BEAT_W'(b)) begin
                rd_data = sel_key[AES_BLOCK_W-1-b*DATA_W -: DATA_W];
            end
        end
    end

endmodule

// File: rtl/anahtar_ekleme_akis.sv
// Streaming AddRoundKey: XORs DATA_W-bit beats of the AES state with the
// matching slice of a round key held in the internal key bank, behind a
// one-deep registered output with valid/ready flow control.
// Build option: define AE_AUTO_ROUND_EN to ignore in_round and step the
// round internally, one round per block, wrapping after NR.
module anahtar_ekleme_akis
    import aes_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int NR     = 10,
    localparam int BEATS  = AES_BLOCK_W / DATA_W,
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_we,
    input  logic [3:0]        key_idx,
    input  logic [127:0]      key_data,
    output logic              key_ready,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [3:0]        in_round,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    logic [BEAT_W-1:0] beat;
    round_idx_t        rnd;
    round_idx_t        round_sel;
    round_idx_t        slot_sel;
    logic [DATA_W-1:0] key_slice;
    logic              accept;
    logic              last_beat;
    logic              out_en;

    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic              last_p1;

    assign out_en    = out_ready || !vld_p1;
    assign in_ready  = out_en;
    assign accept    = in_valid && in_ready;
    assign last_beat = (beat == BEAT_W'(BEATS - 1));
    assign key_ready = (beat == '0);

`ifdef AE_AUTO_ROUND_EN
    logic unused_in_round;
    assign unused_in_round = ^in_round;
    assign round_sel       = rnd;
`else
    assign round_sel = key_ready ? round_idx_t'(in_round) : rnd;
`endif

    assign slot_sel = wrap_slot(round_sel, NR);

    // Key writes only land between blocks so a block never sees a mixed key.
    ae_key_bank #(
        .DATA_W (DATA_W),
        .NR     (NR)
    ) u_key_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (key_we && key_ready),
        .wr_slot (key_idx),
        .wr_data (key_data),
        .rd_slot (slot_sel),
        .rd_beat (beat),
        .rd_data (key_slice)
    );

    // Beat position within the current block; wraps after the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat <= '0;
        end else if (accept) begin
            beat <= last_beat ? '0 : beat + 1'b1;
        end
    end

`ifdef AE_AUTO_ROUND_EN
    // Internal round counter: advances once per completed block, 0..NR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd <= '0;
        end else if (accept && last_beat) begin
            rnd <= (rnd == round_idx_t'(NR)) ? '0 : rnd + 1'b1;
        end
    end
`else
    // Round capture: held from the first beat for the rest of the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd <= '0;
        end else if (accept && key_ready) begin
            rnd <= round_idx_t'(in_round);
        end
    end
`endif

    // ---- stage p1: registered output, held while downstream stalls ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
        end else if (out_en) begin
            vld_p1 <= accept;
            if (accept) begin
                data_p1 <= in_data ^ key_slice;
                last_p1 <= last_beat;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_last  = last_p1;

endmodule

// File: tb/tb_anahtar_ekleme_akis.sv
// Self-checking bench for anahtar_ekleme_akis (DATA_W=32 main instance plus
// a DATA_W=128 instance for the single-beat vector). Honours AE_AUTO_ROUND_EN
// in its reference model.
module tb_anahtar_ekleme_akis;

    localparam int DATA_W = 32;
    localparam int NR     = 10;
    localparam int BEATS  = 128 / DATA_W;

    localparam logic [127:0] KEY_V  = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] DATA_V = 128'h54776F204F6E65204E696E652054776F;
    localparam logic [127:0] EXP_V  = 128'h001F0E543C4E08596E221B0B4774311A;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              key_we, key_ready, in_valid, in_ready;
    logic              out_valid, out_ready, out_last;
    logic [3:0]        key_idx, in_round;
    logic [127:0]      key_data;
    logic [DATA_W-1:0] in_data, out_data;

    logic         w_key_we, w_key_ready, w_in_valid, w_in_ready;
    logic         w_out_valid, w_out_ready, w_out_last;
    logic [3:0]   w_key_idx, w_in_round;
    logic [127:0] w_key_data, w_in_data, w_out_data;

    anahtar_ekleme_akis #(.DATA_W(DATA_W), .NR(NR)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .key_we(key_we), .key_idx(key_idx), .key_data(key_data), .key_ready(key_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_round(in_round),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    anahtar_ekleme_akis #(.DATA_W(128), .NR(NR)) u_dut_w (
        .clk(clk), .rst_n(rst_n),
        .key_we(w_key_we), .key_idx(w_key_idx), .key_data(w_key_data), .key_ready(w_key_ready),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data), .in_round(w_in_round),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data), .out_last(w_out_last)
    );

    // Reference model state: key schedule, block position, round, output register.
    logic [127:0]      keys [0:NR];
    int                m_beat;
    int                m_rnd;
    bit                m_out_valid;
    logic [DATA_W-1:0] m_out_data;
    bit                m_out_last;

    int                n_tests = 0;
    int                n_fail  = 0;
    logic [DATA_W-1:0] coll [$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int s = 0; s <= NR; s++) keys[s] = '0;
        m_beat      = 0;
        m_rnd       = 0;
        m_out_valid = 1'b0;
        m_out_data  = '0;
        m_out_last  = 1'b0;
    endtask

    // One clock: check outputs mid-cycle, advance the model by this edge.
    task automatic cycle(output bit acc);
        int                r, slot;
        logic [127:0]      k;
        logic [DATA_W-1:0] nd;
        bit                nl, rdy;
        @(negedge clk);
        rdy = !m_out_valid || out_ready;
        chk("out_valid", 128'(out_valid), 128'(m_out_valid));
        chk("in_ready",  128'(in_ready),  128'(rdy));
        chk("key_ready", 128'(key_ready), 128'(m_beat == 0));
        chk("out_data",  128'(out_data),  128'(m_out_data));
        chk("out_last",  128'(out_last),  128'(m_out_last));
        if (out_valid && out_ready) coll.push_back(out_data);
        acc = in_valid && rdy;
        nd  = '0;
        nl  = 1'b0;
        if (acc) begin
`ifdef AE_AUTO_ROUND_EN
            r = m_rnd;
`else
            r = (m_beat == 0) ? int'(in_round) : m_rnd;
`endif
            slot = r % (NR + 1);
            k    = keys[slot] >> ((BEATS - 1 - m_beat) * DATA_W);
            nd   = in_data ^ k[DATA_W-1:0];
            nl   = (m_beat == BEATS - 1);
        end
        if (out_ready || !m_out_valid) begin
            m_out_valid = acc;
            if (acc) begin
                m_out_data = nd;
                m_out_last = nl;
            end
        end
        if (key_we && m_beat == 0 && int'(key_idx) <= NR) keys[key_idx] = key_data;
        if (acc) begin
`ifndef AE_AUTO_ROUND_EN
            if (m_beat == 0) m_rnd = int'(in_round);
`endif
            if (m_beat == BEATS - 1) begin
                m_beat = 0;
`ifdef AE_AUTO_ROUND_EN
                m_rnd = (m_rnd == NR) ? 0 : m_rnd + 1;
`endif
            end else begin
                m_beat++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(a);
    endtask

    // Present one beat and hold it until accepted, bounded.
    task automatic send_beat(input logic [DATA_W-1:0] d, input logic [3:0] r);
        bit a;
        a        = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_round = r;
        for (int i = 0; i < 40 && !a; i++) cycle(a);
        if (!a) chk("accept_timeout", 128'(0), 128'(1));
        in_valid = 1'b0;
    endtask

    task automatic write_key(input logic [3:0] idx, input logic [127:0] kd);
        bit a;
        key_we   = 1'b1;
        key_idx  = idx;
        key_data = kd;
        cycle(a);
        key_we   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        key_we   = 1'b0;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out_data", 128'(out_data), 128'(0));
        chk("rst_out_last", 128'(out_last), 128'(0));
        rst_n = 1'b1;
    endtask

    initial begin
        logic [DATA_W-1:0] pd [0:BEATS-1];
        logic [127:0]      exp_blk;
        bit                a;

        rst_n      = 1'b0;
        key_we     = 1'b0; key_idx = '0; key_data = '0;
        in_valid   = 1'b0; in_data = '0; in_round = '0;
        out_ready  = 1'b1;
        w_key_we   = 1'b0; w_key_idx = '0; w_key_data = '0;
        w_in_valid = 1'b0; w_in_data = '0; w_in_round = '0;
        w_out_ready = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        do_reset();
        idle(1);

        // Single-beat instance: the whole block in one cycle.
        w_key_we = 1'b1; w_key_idx = 4'd0; w_key_data = KEY_V;
        idle(1);
        w_key_we = 1'b0;
        w_in_valid = 1'b1; w_in_data = DATA_V; w_in_round = 4'd0;
        idle(1);
        w_in_valid = 1'b0;
        chk("w_out_valid", 128'(w_out_valid), 128'(1));
        chk("w_out_data",  w_out_data,        EXP_V);
        chk("w_out_last",  128'(w_out_last),  128'(1));

        // Known vector as four beats; in_round on later beats must be ignored.
        write_key(4'd0, KEY_V);
        coll.delete();
        for (int b = 0; b < BEATS; b++) send_beat(DATA_V[127-b*DATA_W -: DATA_W], (b == 0) ? 4'd0 : 4'd7);
        idle(2);
        chk("vec_count", 128'(coll.size()), 128'(BEATS));
        for (int b = 0; b < BEATS && b < coll.size(); b++)
            chk("vec_beat", 128'(coll[b]), 128'(EXP_V[127-b*DATA_W -: DATA_W]));

        // Downstream stall after the second beat.
        coll.delete();
`ifdef AE_AUTO_ROUND_EN
        exp_blk = DATA_V;
`else
        exp_blk = EXP_V;
`endif
        send_beat(DATA_V[127 -: DATA_W], 4'd0);
        send_beat(DATA_V[95 -: DATA_W], 4'd0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DATA_V[63 -: DATA_W];
        idle(5);
        chk("stall_hold", 128'(out_data), 128'(exp_blk[95 -: DATA_W]));
        out_ready = 1'b1;
        send_beat(DATA_V[63 -: DATA_W], 4'd0);
        send_beat(DATA_V[31 -: DATA_W], 4'd0);
        idle(2);
        chk("stall_count", 128'(coll.size()), 128'(BEATS));
        for (int b = 0; b < BEATS && b < coll.size(); b++)
            chk("stall_beat", 128'(coll[b]), 128'(exp_blk[127-b*DATA_W -: DATA_W]));

        // Key write mid-block is dropped, retried at beat 0 it lands.
        send_beat(32'h11111111, 4'd0);
        send_beat(32'h22222222, 4'd0);
        key_we = 1'b1; key_idx = 4'd0; key_data = {4{32'hA5A5_0F0F}};
        send_beat(32'h33333333, 4'd0);
        key_we = 1'b0;
        send_beat(32'h44444444, 4'd0);
        for (int b = 0; b < BEATS; b++) send_beat($urandom, 4'd0);
        write_key(4'd0, {4{32'hA5A5_0F0F}});
        for (int b = 0; b < BEATS; b++) send_beat($urandom, 4'd0);
        write_key(4'd12, {4{32'hDEAD_BEEF}});
        idle(2);

        // Reset in the middle of a block, then a pass-through block.
        send_beat(32'h01234567, 4'd0);
        send_beat(32'h89ABCDEF, 4'd0);
        do_reset();
        idle(1);
        coll.delete();
        for (int b = 0; b < BEATS; b++) begin
            pd[b] = $urandom;
            send_beat(pd[b], 4'($urandom_range(0, 15)));
        end
        idle(2);
        chk("pass_count", 128'(coll.size()), 128'(BEATS));
        for (int b = 0; b < BEATS && b < coll.size(); b++)
            chk("pass_beat", 128'(coll[b]), 128'(pd[b]));

        // Random traffic: keys, rounds (incl. illegal), backpressure.
        for (int s = 0; s <= NR; s++) write_key(4'(s), {$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = $urandom;
            in_round  = 4'($urandom % 16);
            out_ready = ($urandom % 4) != 0;
            key_we    = ($urandom % 6) == 0;
            key_idx   = 4'($urandom % 16);
            key_data  = {$urandom, $urandom, $urandom, $urandom};
            cycle(a);
        end
        in_valid  = 1'b0;
        key_we    = 1'b0;
        out_ready = 1'b1;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/anahtar_ekleme_akis.md
# anahtar_ekleme_akis

Streaming, parametrised AddRoundKey unit for the AES datapath. It stores the full expanded round-key schedule in an internal register bank. It accepts the 128-bit state as DATA_W-bit beats over a valid/ready handshake and XORs each beat with the matching slice of the selected round key. The result is emitted through a registered output stage. It sits between the MixColumns stage and the next round's SubBytes, and replaces the single-shot combinational 128-bit key-add.

## Interface
- DATA_W, 32: beat width in bits; legal values 32, 64, 128. BEATS = 128/DATA_W.
- NR, 10: number of AES rounds (10/12/14). Key bank depth is NR+1.
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_we  in  1  write the round key on key_data into slot key_idx.
- key_idx  in  4  key slot, 0..NR.
- key_data  in  128  round key, MSB = first byte.
- key_ready  out  1  key bank writable.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  DATA_W  state beat.
- in_round  in  4  round index; sampled on the first beat of a block only.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_data  out  DATA_W  keyed state beat.
- out_last  out  1  marks the final beat (BEATS-1) of a block.

## Operation
- Beat ordering: beat b carries state bits [127-b·DATA_W : 128-(b+1)·DATA_W], so beat 0 holds the most-significant bytes.
- Beat counter `beat` runs 0..BEATS-1 and wraps to 0 after the last accepted beat.
- Round register `rnd` is loaded from in_round when a beat is accepted with beat==0.
  - For beats >0, the round used is the value captured in `rnd`; in_round is ignored.
- Output beat = in_data XOR key_bank[round][slice b], where round = in_round when beat==0, otherwise `rnd`.
- in_round > NR is illegal. The unit uses key slot in_round mod (NR+1) and continues normally; it does not hang.
- key_ready = (beat==0). Key writes issued while key_ready is low are dropped.
- A key write and a first-beat accept in the same cycle: the beat uses the old key contents, and the write lands at the clock edge.
- key_idx > NR on a write is ignored.

## Timing
- Latency: one cycle from accept to out_valid. Throughput: one beat per cycle.
- in_ready = !out_valid || out_ready. There is no combinational path from in_valid to out_valid.
- out_data, out_last and out_valid change only when (out_ready || !out_valid).
  - Downstream stall holds the output stable; out_data never changes while out_valid && !out_ready.
- Reset values: out_valid=0, out_data=0, out_last=0, beat=0, rnd=0, all key slots=0. key_ready=1 and in_ready=1 one cycle after reset release.
- Reset asserted mid-block discards the partial block; the next accepted beat is treated as beat 0.

## Configuration
- AE_AUTO_ROUND_EN defined:
  - in_round is ignored. `rnd` is an internal counter that starts at 0 after reset.
  - The counter increments when the last beat of a block is accepted, and wraps from NR to 0.
- AE_AUTO_ROUND_EN undefined: the round is taken from in_round on the first beat as described above, and no counter is built.

## Structure
- Shared package aes_pkg holds: AES_BLOCK_W=128, the NR constants (10/12/14), the round-index type (4 bits) and the state-word type.
- One sub-module, ae_key_bank: an (NR+1)×128 register file with async reset, a write port, and a combinational read of slot/slice (slot, beat). It is reused later by the inverse-cipher path.

## Test plan
- DATA_W=128, key slot 0 = 5468617473206D79204B756E67204675, in_data = 54776F204F6E65204E696E652054776F, in_round=0 -> out_data = 001F0E543C4E08596E221B0B4774311A one cycle later, with out_last=1.
- DATA_W=32, same vector as four beats -> out beats 001F0E54, 3C4E0859, 6E221B0B, 4774311A, with out_last only on the fourth beat.
- DATA_W=32, out_ready held low for 5 cycles after the second beat -> out_data stays 3C4E0859, in_ready=0, and no beat is lost or duplicated after release.
- Key write to slot 0 while beat=2 -> write dropped. Subsequent block uses the old key; the write is retried at beat 0 and then takes effect.
- Reset pulsed after beat 1 of a block -> out_valid=0 and all keys=0. A fresh 4-beat block with key 0 = 0 passes in_data through unchanged.
- AE_AUTO_ROUND_EN, NR=10, 12 blocks with slot k = k repeated -> blocks use rounds 0..10 then 0, regardless of in_round.
